// File: rtl/uart_tx_frame.sv
// Purpose : UART transmitter: start bit, DATA_WIDTH data bits LSB first,
//           optional parity bit, stop bit(s); one serial bit per clk cycle.
// Latency : start bit appears on tx_out at the first edge after the acceptance edge.
// Backpr. : no queuing; data_valid is only accepted while the FSM is idle, else dropped.
//
// Ports:
//   clk        TX bit clock (baud-rate clock)
//   rst        asynchronous, active-low reset
//   p_data     parallel word, sampled on the acceptance edge only
//   data_valid single-cycle request strobe
//   par_en     1 = append a parity bit after the data bits
//   par_typ    0 = even parity, 1 = odd parity
//   tx_out     serial line, idle high, straight from a flop
//   busy       high for every cycle a frame bit is on tx_out, registered
//
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
//
// Timing note: tx_out/busy are registered from the current state, so the line
// lags the FSM by one cycle. The FSM is back in IDLE while the stop bit is on
// the line, which is what lets a held data_valid restart after exactly one
// idle-high cycle.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
          // Only point where the inputs are sampled; later changes are ignored.
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          state_d   = START;
        end
      end

      START: begin
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        bit_cnt_d = '0;
        state_d   = DATA;
      end

      DATA: begin
        tx_d   = data_q[bit_cnt_q];
        busy_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        // XOR of the data makes the total ones count even; par_typ flips it to odd.
        tx_d      = (^data_q) ^ par_typ_q;
        busy_d    = 1'b1;
        bit_cnt_d = '0;
        state_d   = STOP;
      end

      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        // The bit counter is free here, so it counts the two stop cycles.
        if (bit_cnt_q == '0) begin
          bit_cnt_d = CNT_W'(1);
        end else begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
`else
        bit_cnt_d = '0;
        state_d   = IDLE;
`endif
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule
